// File: rtl/weight_load_scheduler_if.sv
// Bundle of every handshake and bus signal around weight_load_scheduler.
//   master : host/DMA side (issues commands, sources the weight stream, reports buffer busy)
//   slave  : the scheduler itself
// Signals:
//   cfg_valid/cfg_ready/cfg_kernel_size/cfg_pe_mask  load command channel
//   abort                                            synchronous abort of the current load
//   s_valid/s_ready/s_data                           shared weight stream
//   wb_busy/wb_flush/wb_wr_en/wb_data/wb_kernel_size per-PE weight buffer port
//   busy/done/err_size                               status
interface weight_load_scheduler_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_PE     = 4
);
  logic                  cfg_valid;
  logic                  cfg_ready;
  logic [7:0]            cfg_kernel_size;
  logic [NUM_PE-1:0]     cfg_pe_mask;
  logic                  abort;
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data;
  logic [NUM_PE-1:0]     wb_busy;
  logic [NUM_PE-1:0]     wb_flush;
  logic [NUM_PE-1:0]     wb_wr_en;
  logic [DATA_WIDTH-1:0] wb_data;
  logic [7:0]            wb_kernel_size;
  logic                  busy;
  logic                  done;
  logic                  err_size;

  modport master (
    output cfg_valid, cfg_kernel_size, cfg_pe_mask, abort, s_valid, s_data, wb_busy,
    input  cfg_ready, s_ready, wb_flush, wb_wr_en, wb_data, wb_kernel_size, busy, done, err_size
  );

  modport slave (
    input  cfg_valid, cfg_kernel_size, cfg_pe_mask, abort, s_valid, s_data, wb_busy,
    output cfg_ready, s_ready, wb_flush, wb_wr_en, wb_data, wb_kernel_size, busy, done, err_size
  );
endinterface

// File: rtl/weight_load_scheduler.sv
// Sequences kernel-weight loading into NUM_PE weight buffers from one shared stream.
// A command (kernel size, PE mask) is accepted in IDLE; selected PEs are then visited in
// ascending index: each is armed with a one-cycle flush pulse (once its buffer is not busy)
// and receives exactly kernel_size stream words before the next PE is selected.
// Ports:
//   clk   clock
//   rstn  asynchronous active-low reset
//   bus   weight_load_scheduler_if.slave (command, stream, buffer and status signals)
// The interface instance must be parameterised with the same DATA_WIDTH and NUM_PE.
module weight_load_scheduler #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_PE     = 4,
  parameter int unsigned MAX_KSIZE  = 16
) (
  input logic                     clk,
  input logic                     rstn,
  weight_load_scheduler_if.slave  bus
);

  localparam int unsigned PeW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StSelect,
    StArm,
    StStream,
    StDone
  } state_e;

  state_e            state_q;
  logic [NUM_PE-1:0] remaining_q;
  logic [PeW-1:0]    cur_pe_q;
  logic [7:0]        count_q;
  logic [7:0]        ksize_q;
  logic              cfg_ready_q;
  logic              done_q;
  logic              err_size_q;

  logic              size_ok;
  logic              arm_go;
  logic              stream_en;
  logic              beat;
  logic [NUM_PE-1:0] cur_onehot;

  function automatic logic [PeW-1:0] lowest_set(input logic [NUM_PE-1:0] m);
    lowest_set = '0;
    for (int i = int'(NUM_PE) - 1; i >= 0; i--) begin
      if (m[i]) lowest_set = PeW'(i);
    end
  endfunction

  // Abort gates every strobe in its own cycle, so nothing reaches a buffer while unwinding.
  always_comb begin
    size_ok    = (bus.cfg_kernel_size != 8'd0) && (bus.cfg_kernel_size <= 8'(MAX_KSIZE));
    cur_onehot = NUM_PE'(1) << cur_pe_q;
    arm_go     = (state_q == StArm) && !bus.abort && !bus.wb_busy[cur_pe_q];
    stream_en  = (state_q == StStream) && !bus.abort;
    beat       = stream_en && bus.s_valid;
  end

  always_comb begin
    bus.cfg_ready      = cfg_ready_q;
    bus.s_ready        = stream_en;
    bus.wb_flush       = arm_go ? cur_onehot : '0;
    bus.wb_wr_en       = beat ? cur_onehot : '0;
    bus.wb_data        = beat ? bus.s_data : '0;
    bus.wb_kernel_size = ksize_q;
    bus.busy           = (state_q != StIdle);
    bus.done           = done_q;
    bus.err_size       = err_size_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      cur_pe_q    <= '0;
      count_q     <= '0;
      ksize_q     <= '0;
      cfg_ready_q <= 1'b1;
      done_q      <= 1'b0;
      err_size_q  <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      err_size_q <= 1'b0;
      if (bus.abort && (state_q != StIdle)) begin
        state_q     <= StIdle;
        remaining_q <= '0;
        cfg_ready_q <= 1'b1;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (bus.cfg_valid) begin
              if (!size_ok) begin
                // Rejected: latched size and mask keep their previous values.
                err_size_q <= 1'b1;
              end else begin
                ksize_q     <= bus.cfg_kernel_size;
                remaining_q <= bus.cfg_pe_mask;
                cfg_ready_q <= 1'b0;
                state_q     <= StSelect;
              end
            end
          end
          StSelect: begin
            if (remaining_q == '0) begin
              done_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              cur_pe_q <= lowest_set(remaining_q);
              state_q  <= StArm;
            end
          end
          StArm: begin
            if (!bus.wb_busy[cur_pe_q]) begin
              count_q <= '0;
              state_q <= StStream;
            end
          end
          StStream: begin
            if (bus.s_valid) begin
              count_q <= count_q + 8'd1;
              if (count_q == ksize_q - 8'd1) begin
                remaining_q[cur_pe_q] <= 1'b0;
                state_q               <= StSelect;
              end
            end
          end
          StDone: begin
            cfg_ready_q <= 1'b1;
            state_q     <= StIdle;
          end
          default: begin
            cfg_ready_q <= 1'b1;
            state_q     <= StIdle;
          end
        endcase
      end
    end
  end

endmodule
